// File: rtl/dtpu_ctrl_pkg.sv
// Shared definitions for the tile sequencer control path.
//   state_t  : sequencer state encoding (also exported on the debug port)
//   pipe_lat : number of MXU pipeline steps from input accept to result
package dtpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic int pipe_lat(input int rows, input int columns);
    return rows + columns - 1;
  endfunction

endpackage

// File: rtl/mxu_valid_delay.sv
// Enable-gated valid shift register tracking which MXU pipeline slots carry a
// real input vector. Shifts only when the array advances.
//   clk   : clock
//   reset : synchronous, active-low; clears the register
//   en    : advance one step (shift din in at bit 0)
//   din   : valid flag entering the pipeline
//   clr   : synchronous clear (tile abort)
//   dout  : valid flag of the slot leaving the pipeline
module mxu_valid_delay #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic din,
  input  logic clr,
  output logic dout
);

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      r_sr <= '0;
    end else if (en) begin
      // Shift form that stays legal for DEPTH == 1.
      r_sr <= (r_sr << 1) | DEPTH'(din);
    end
  end

  assign dout = r_sr[DEPTH-1];

endmodule

// File: rtl/mxu_tile_sequencer.sv
// Sequences one tile through the systolic MXU: loads ROWS weight rows, streams
// batch_len input vectors, then drains exactly batch_len results.
//   clk, reset            : clock, synchronous active-low reset
//   start, abort          : tile request (IDLE only) / synchronous cancel
//   batch_len, wbase      : tile size and first weight row address (latched on start)
//   busy, done            : status; done is a one-cycle completion pulse
//   wm_ce, wm_address     : weight memory read port
//   load_weights          : MXU latches the weight row on the memory data bus
//   infifo_is_empty/read  : input FIFO handshake (first-word fall-through)
//   enable_mxu            : advance MXU pipeline one step
//   outfifo_is_full/write : output FIFO handshake
//   state_out             : debug view of the current state
module mxu_tile_sequencer
  import dtpu_ctrl_pkg::*;
#(
  parameter int ROWS                 = 3,
  parameter int COLUMNS              = 3,
  parameter int ADDRESS_SIZE_WMEMORY = 32,
  parameter int BATCH_WIDTH          = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic [BATCH_WIDTH-1:0]          batch_len,
  input  logic [ADDRESS_SIZE_WMEMORY-1:0] wbase,
  output logic                            busy,
  output logic                            done,
  output logic                            wm_ce,
  output logic [ADDRESS_SIZE_WMEMORY-1:0] wm_address,
  output logic                            load_weights,
  input  logic                            infifo_is_empty,
  output logic                            infifo_read,
  output logic                            enable_mxu,
  input  logic                            outfifo_is_full,
  output logic                            outfifo_write,
  output logic [2:0]                      state_out
);

  localparam int PIPE_LAT = pipe_lat(ROWS, COLUMNS);
  localparam int CNT_W    = $clog2(ROWS + 1);
  localparam logic [CNT_W-1:0]       LAST_ROW = CNT_W'(ROWS);
  localparam logic [BATCH_WIDTH-1:0] ONE_B    = BATCH_WIDTH'(1);

  state_t                          r_state, w_state_nxt;
  logic [CNT_W-1:0]                r_cnt, w_cnt_nxt;
  logic [BATCH_WIDTH-1:0]          r_sent, w_sent_nxt;
  logic [BATCH_WIDTH-1:0]          r_recv, w_recv_nxt;
  logic [BATCH_WIDTH-1:0]          r_len;
  logic [ADDRESS_SIZE_WMEMORY-1:0] r_wbase;

  logic w_latch, w_wm_ce, w_load, w_read, w_en, w_shift_in, w_write, w_vld_out;

  mxu_valid_delay #(.DEPTH(PIPE_LAT)) u_vld (
    .clk   (clk),
    .reset (reset),
    .en    (w_en),
    .din   (w_shift_in),
    .clr   (abort),
    .dout  (w_vld_out)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sent  <= '0;
      r_recv  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sent  <= w_sent_nxt;
      r_recv  <= w_recv_nxt;
    end
  end

  // Tile parameters are plain data: captured on start, no reset needed.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_len   <= batch_len;
      r_wbase <= wbase;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sent_nxt  = r_sent;
    w_recv_nxt  = r_recv;
    w_latch     = 1'b0;
    w_wm_ce     = 1'b0;
    w_load      = 1'b0;
    w_read      = 1'b0;
    w_en        = 1'b0;
    w_shift_in  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = '0;
          w_sent_nxt  = '0;
          w_recv_nxt  = '0;
          w_state_nxt = (batch_len == '0) ? DONE : LOAD_W;
        end
      end
      LOAD_W: begin
        w_wm_ce = (r_cnt < LAST_ROW);
        // Memory data arrives one cycle after the address.
        w_load  = (r_cnt != '0);
        if (r_cnt == LAST_ROW) w_state_nxt = STREAM;
        else                   w_cnt_nxt   = r_cnt + 1'b1;
      end
      STREAM: begin
        // The array may only advance when a vector is available and a
        // result (if one emerges) has somewhere to go.
        if (!infifo_is_empty && !outfifo_is_full) begin
          w_read     = 1'b1;
          w_en       = 1'b1;
          w_shift_in = 1'b1;
          w_sent_nxt = r_sent + ONE_B;
          if ((r_sent + ONE_B) == r_len) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_en = !outfifo_is_full;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_write = w_en && w_vld_out;
    if (w_write) begin
      w_recv_nxt = r_recv + ONE_B;
      if (r_state == DRAIN && (r_recv + ONE_B) == r_len) w_state_nxt = DONE;
    end

    if (abort) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_sent_nxt  = '0;
      w_recv_nxt  = '0;
    end
  end

  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE);
  assign wm_ce         = w_wm_ce;
  assign wm_address    = w_wm_ce ? (r_wbase + ADDRESS_SIZE_WMEMORY'(r_cnt)) : '0;
  assign load_weights  = w_load;
  assign infifo_read   = w_read;
  assign enable_mxu    = w_en;
  assign outfifo_write = w_write;
  assign state_out     = r_state;

endmodule

// File: tb/tb_mxu_tile_sequencer.sv
// Bench for mxu_tile_sequencer: a transaction-level model (phase flags plus a
// queue of in-flight tokens with their step ages) is compared against every
// output on every falling edge; directed tiles are also pinned by hand-computed
// cycle masks.
module tb_mxu_tile_sequencer;

  localparam int ROWS = 3;
  localparam int PL   = 5;

  logic        clk = 1'b0;
  logic        reset, start, abort, infifo_is_empty, outfifo_is_full;
  logic [15:0] batch_len;
  logic [31:0] wbase;
  logic        busy, done, wm_ce, load_weights, infifo_read, enable_mxu, outfifo_write;
  logic [31:0] wm_address;
  logic [2:0]  state_out;

  always #5 clk = ~clk;

  mxu_tile_sequencer #(
    .ROWS(3), .COLUMNS(3), .ADDRESS_SIZE_WMEMORY(32), .BATCH_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .batch_len(batch_len), .wbase(wbase),
    .busy(busy), .done(done), .wm_ce(wm_ce), .wm_address(wm_address),
    .load_weights(load_weights), .infifo_is_empty(infifo_is_empty),
    .infifo_read(infifo_read), .enable_mxu(enable_mxu),
    .outfifo_is_full(outfifo_is_full), .outfifo_write(outfifo_write),
    .state_out(state_out)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy, m_pend_done;
  int          m_k;          // weight row phase index, -1 when not loading
  int          m_len, m_acc, m_wr;
  logic [31:0] m_base;
  int          m_q[$];       // steps taken by each in-flight token since accept

  function automatic bit m_active();
    return m_busy && (m_k < 0) && !m_pend_done;
  endfunction

  function automatic bit m_stream();
    return m_active() && (m_acc < m_len);
  endfunction

  function automatic bit m_step();
    if (!m_active()) return 1'b0;
    if (m_stream())  return !infifo_is_empty && !outfifo_is_full;
    return !outfifo_is_full;
  endfunction

  function automatic bit m_write();
    return m_step() && (m_q.size() > 0) && (m_q[0] == PL - 1);
  endfunction

  task automatic model_clear();
    m_busy = 0; m_pend_done = 0; m_k = -1; m_acc = 0; m_wr = 0; m_q.delete();
  endtask

  // Called right at each rising edge, before inputs change.
  task automatic model_update();
    bit st, wr, rd;
    if (!reset || abort) begin
      model_clear();
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_len = int'(batch_len); m_base = wbase;
        m_acc = 0; m_wr = 0; m_q.delete();
        if (m_len == 0) m_pend_done = 1;
        else            m_k = 0;
      end
    end else if (m_pend_done) begin
      model_clear();
    end else if (m_k >= 0) begin
      if (m_k == ROWS) m_k = -1;
      else             m_k++;
    end else begin
      st = m_step();
      wr = m_write();
      rd = st && m_stream();
      if (wr) void'(m_q.pop_front());
      if (st) for (int i = 0; i < m_q.size(); i++) m_q[i]++;
      if (rd) begin m_q.push_back(0); m_acc++; end
      if (wr) begin
        m_wr++;
        if (m_wr == m_len) m_pend_done = 1;
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic        e_ce, e_ld, e_st, e_rd, e_wr;
      logic [31:0] e_addr;
      logic [2:0]  e_state;
      e_ce   = (m_k >= 0) && (m_k < ROWS);
      e_addr = e_ce ? (m_base + 32'(m_k)) : 32'h0;
      e_ld   = (m_k >= 1);
      e_st   = m_step();
      e_rd   = e_st && m_stream();
      e_wr   = m_write();
      if (!m_busy)           e_state = 3'd0;
      else if (m_pend_done)  e_state = 3'd4;
      else if (m_k >= 0)     e_state = 3'd1;
      else if (m_stream())   e_state = 3'd2;
      else                   e_state = 3'd3;
      chk("busy",          32'(busy),          32'(m_busy));
      chk("done",          32'(done),          32'(m_pend_done));
      chk("wm_ce",         32'(wm_ce),         32'(e_ce));
      chk("wm_address",    wm_address,         e_addr);
      chk("load_weights",  32'(load_weights),  32'(e_ld));
      chk("infifo_read",   32'(infifo_read),   32'(e_rd));
      chk("enable_mxu",    32'(enable_mxu),    32'(e_st));
      chk("outfifo_write", 32'(outfifo_write), 32'(e_wr));
      chk("state_out",     32'(state_out),     32'(e_state));
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] rd_mask, wr_mask, ld_mask, ce_mask, done_mask, busy_mask;
  logic [31:0] addr_rec [3];
  int          first_done, nwr;

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic bit_at(input logic [31:0] m, input int t);
    logic [31:0] v;
    v = m;
    if (t < 0 || t > 31) return 1'b0;
    return v[t[4:0]];
  endfunction

  task automatic run_tile(input int len, input logic [31:0] base, input int ncyc,
                          input logic [31:0] emask, input logic [31:0] fmask,
                          input int abort_at, input int restart_at);
    rd_mask = 0; wr_mask = 0; ld_mask = 0; ce_mask = 0; done_mask = 0; busy_mask = 0;
    first_done = -1; nwr = 0;
    for (int i = 0; i < 3; i++) addr_rec[i] = 32'hDEAD_BEEF;
    for (int t = 0; t < ncyc; t++) begin
      start           = (t == 0) || (t == restart_at);
      batch_len       = len[15:0];
      wbase           = base;
      infifo_is_empty = bit_at(emask, t);
      outfifo_is_full = bit_at(fmask, t);
      abort           = (t == abort_at);
      @(negedge clk);
      if (t < 32) begin
        rd_mask[t[4:0]]   = infifo_read;
        wr_mask[t[4:0]]   = outfifo_write;
        ld_mask[t[4:0]]   = load_weights;
        ce_mask[t[4:0]]   = wm_ce;
        done_mask[t[4:0]] = done;
        busy_mask[t[4:0]] = busy;
      end
      if (t >= 1 && t <= 3) addr_rec[t-1] = wm_address;
      if (outfifo_write) nwr++;
      if (done && first_done < 0) first_done = t;
      tick();
    end
    start = 0; abort = 0; infifo_is_empty = 0; outfifo_is_full = 0;
  endtask

  initial begin
    reset = 0; start = 0; abort = 0; infifo_is_empty = 0; outfifo_is_full = 0;
    batch_len = '0; wbase = '0;
    model_clear();
    tick();
    chk_en = 1'b1;
    tick(); tick();
    chk("reset_state", 32'(state_out), 32'd0);
    chk("reset_busy",  32'(busy),      32'd0);
    chk("reset_done",  32'(done),      32'd0);
    reset = 1;
    tick(); tick();

    // 1: nominal tile
    run_tile(4, 32'h10, 17, 0, 0, -1, -1);
    chk("c1_addr0", addr_rec[0], 32'h10);
    chk("c1_addr1", addr_rec[1], 32'h11);
    chk("c1_addr2", addr_rec[2], 32'h12);
    chk("c1_ce",    ce_mask,   32'h0000_000E);
    chk("c1_load",  ld_mask,   32'h0000_001C);
    chk("c1_read",  rd_mask,   32'h0000_01E0);
    chk("c1_write", wr_mask,   32'h0000_3C00);
    chk("c1_done",  done_mask, 32'h0000_4000);
    chk("c1_busy",  busy_mask, 32'h0000_7FFE);
    tick(); tick();

    // 2: empty tile
    run_tile(0, 32'h10, 4, 0, 0, -1, -1);
    chk("c2_done",  done_mask, 32'h0000_0002);
    chk("c2_busy",  busy_mask, 32'h0000_0002);
    chk("c2_ce",    ce_mask,   32'h0);
    chk("c2_read",  rd_mask,   32'h0);
    chk("c2_write", wr_mask,   32'h0);
    tick(); tick();

    // 3: input FIFO empty at cycles 6-7
    run_tile(4, 32'h10, 19, 32'h0000_00C0, 0, -1, -1);
    chk("c3_read",  rd_mask,   32'h0000_0720);
    chk("c3_write", wr_mask,   32'h0000_F000);
    chk("c3_done",  done_mask, 32'h0001_0000);
    chk("c3_busy",  busy_mask, 32'h0001_FFFE);
    tick(); tick();

    // 4: output FIFO full at cycles 11-12
    run_tile(4, 32'h10, 19, 0, 32'h0000_1800, -1, -1);
    chk("c4_read",  rd_mask,   32'h0000_01E0);
    chk("c4_write", wr_mask,   32'h0000_E400);
    chk("c4_nwr",   32'(nwr),  32'd4);
    chk("c4_done",  done_mask, 32'h0001_0000);
    tick(); tick();

    // 5: abort at cycle 11, then a fresh 2-vector tile
    run_tile(4, 32'h10, 14, 0, 0, 11, -1);
    chk("c5_write", wr_mask,   32'h0000_0C00);
    chk("c5_done",  done_mask, 32'h0);
    chk("c5_busy",  busy_mask, 32'h0000_0FFE);
    run_tile(2, 32'h20, 14, 0, 0, -1, -1);
    chk("c5b_nwr",  32'(nwr),  32'd2);
    chk("c5b_write", wr_mask,  32'h0000_0C00);
    chk("c5b_done", done_mask, 32'h0000_1000);
    tick(); tick();

    // 6: address wrap, start re-pulsed while busy
    run_tile(4, 32'hFFFF_FFFE, 17, 0, 0, -1, 3);
    chk("c6_addr0", addr_rec[0], 32'hFFFF_FFFE);
    chk("c6_addr1", addr_rec[1], 32'hFFFF_FFFF);
    chk("c6_addr2", addr_rec[2], 32'h0000_0000);
    chk("c6_done",  done_mask, 32'h0000_4000);
    chk("c6_busy",  busy_mask, 32'h0000_7FFE);
    tick(); tick();

    // 7: maximum batch length, counters must not wrap
    run_tile(65535, 32'h100, 65550, 0, 0, -1, -1);
    chk("c7_nwr",  32'(nwr),        32'd65535);
    chk("c7_done", 32'(first_done), 32'd65545);
    tick(); tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
